// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUB_SIGNED_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width; never below 1 so WIDTH=1 still has a legal vector.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a client (master) and the serial subtractor (slave).
// The OVF signal exists only when SERIAL_SUB_SIGNED_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] DIFF;
    logic             BORROW;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             OVF;
`endif

    modport master (
        output START, A, B,
`ifdef SERIAL_SUB_SIGNED_EN
        input  OVF,
`endif
        input  BUSY, DONE, DIFF, BORROW
    );

    modport slave (
        input  START, A, B,
`ifdef SERIAL_SUB_SIGNED_EN
        output OVF,
`endif
        output BUSY, DONE, DIFF, BORROW
    );
endinterface

// File: rtl/serial_subtractor_full_sub_cell.sv
// Combinational full subtractor: two cascaded half-subtractor stages,
// the stage borrows ORed into the outgoing borrow.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    assign hs1_diff   = a ^ b;
    assign hs1_borrow = ~a & b;
    assign d          = hs1_diff ^ bin;
    assign hs2_borrow = ~hs1_diff & bin;
    assign bout       = hs1_borrow | hs2_borrow;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single full_sub_cell.
// Define SERIAL_SUB_SIGNED_EN to add the signed-overflow output OVF.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    serial_subtractor_if.slave  bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;
    logic [WIDTH-1:0]   op_b_q,   op_b_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               br_q,     br_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUB_SIGNED_EN
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;
    logic               ovf_q,    ovf_d;
`endif

    logic cell_d;
    logic cell_bout;

    full_sub_cell u_cell (
        .a    (op_a_q[0]),
        .b    (op_b_q[0]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a latch.
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_SIGNED_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    op_a_d  = bus.A;
                    op_b_d  = bus.B;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
`ifdef SERIAL_SUB_SIGNED_EN
                    a_msb_d = bus.A[WIDTH-1];
                    b_msb_d = bus.B[WIDTH-1];
`endif
                end
            end

            SHIFT: begin
                // Result fills from the top so the LSB lands in bit 0 after WIDTH shifts.
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = cell_d;
                op_a_d           = op_a_q >> 1;
                op_b_d           = op_b_q >> 1;
                br_d             = cell_bout;
                cnt_d            = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                diff_d   = res_q;
                borrow_d = br_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef SERIAL_SUB_SIGNED_EN
                ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_q[WIDTH-1]);
`endif
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the datapath registers are reset too, so an aborted operation
        // leaves no partial operands, borrow or result behind.
        if (RST) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.DIFF   = diff_q;
    assign bus.BORROW = borrow_q;
`ifdef SERIAL_SUB_SIGNED_EN
    assign bus.OVF    = ovf_q;
`endif
endmodule
